front_panel_ctrl: RTL and testbench

Parametrised front-panel controller for the SAP-family cores. It owns the panel address register, hex keypad data entry, memory deposit strobes with optional auto-increment, readback of the addressed word, and CPU clock-enable gating. Three run modes are supported: free-run, single-step, and N-cycle burst. It sits between the debounce/keypad front end and the CPU core's fp_* and clken/clken_oop inputs. All pulse inputs are one clk cycle wide and already debounced.

---
 rtl/front_panel_ctrl_if.sv | 16 +
 rtl/front_panel_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_front_panel_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/front_panel_ctrl_if.sv
// Panel-side memory bus: address/data/deposit strobe out, readback data in.
interface front_panel_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] fp_adr;
    logic [DATA_W-1:0] fp_data;
    logic              fp_write;
    logic              busy;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output fp_adr, output fp_data, output fp_write, output busy,
                    input  mem_rdata);
    modport slave  (input  fp_adr, input  fp_data, input  fp_write, input  busy,
                    output mem_rdata);
endinterface

// File: rtl/front_panel_ctrl.sv
// Front-panel controller: address/keypad entry, deposit and readback sequencing,
// and free-run / single-step / burst gating of the CPU clock enables.
module front_panel_ctrl #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int BURST_W  = 8,
    parameter int RD_LAT   = 1,
    parameter int AUTO_INC = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      prog,
    input  logic [ADDR_W-1:0]         adr_init,
    input  logic                      adr_load,
    input  logic                      adr_inc,
    input  logic                      adr_dec,
    input  logic                      key_valid,
    input  logic [3:0]                key_code,
    input  logic                      key_clear,
    input  logic                      write_req,
    input  logic [1:0]                run_mode,
    input  logic                      step_req,
    input  logic [BURST_W-1:0]        burst_len,
    input  logic                      tick,
    input  logic                      tick_oop,
    input  logic                      halt,
    input  logic                      run_restart,
    front_panel_ctrl_if.master        bus,
    output logic [$clog2(DATA_W/4):0] digits,
    output logic                      clken,
    output logic                      clken_oop,
    output logic                      running
);
    localparam int                 DIG_W      = $clog2(DATA_W/4) + 1;
    localparam logic [DIG_W-1:0]   DIG_MAX    = DIG_W'(DATA_W/4);
    localparam logic [DIG_W-1:0]   DIG_ONE    = DIG_W'(1);
    localparam logic [ADDR_W-1:0]  ADR_ONE    = ADDR_W'(1);
    localparam logic [2:0]         RD_CNT     = 3'(RD_LAT);
    localparam logic [BURST_W-1:0] BURST_ONE  = BURST_W'(1);
    localparam logic [BURST_W-1:0] BURST_ZERO = BURST_W'(0);
    localparam logic [1:0]         MODE_STEP  = 2'b01;
    localparam logic [1:0]         MODE_BURST = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        RD_WAIT = 2'd2,
        CAPTURE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DIG_W-1:0]    digits_q, digits_d;
    logic                write_q, write_d;
    logic                busy_q, busy_d;

    logic                running_q, running_d;
    logic [BURST_W-1:0]  rem_q, rem_d;
    logic                phase_q, phase_d;
    logic [1:0]          mode_q, mode_d;
    logic                gate_s, mode_chg_s, stepping_s, pulse_ok_s;
    logic                clken_s, clken_oop_s;

    // Panel FSM next-state: deposit, address change, key entry and readback capture.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adr_d    = adr_q;
        data_d   = data_q;
        digits_d = digits_q;
        case (state_q)
            IDLE: begin
                if (prog && write_req) begin
                    state_d = WRITE;
                end else if (adr_load || (adr_inc ^ adr_dec)) begin
                    if (adr_load) begin
                        adr_d = adr_init;
                    end else if (adr_inc) begin
                        adr_d = adr_q + ADR_ONE;
                    end else begin
                        adr_d = adr_q - ADR_ONE;
                    end
                    state_d = RD_WAIT;
                    cnt_d   = RD_CNT;
                end else if (prog && key_clear) begin
                    data_d   = {DATA_W{1'b0}};
                    digits_d = {DIG_W{1'b0}};
                end else if (prog && key_valid) begin
                    data_d   = {data_q[DATA_W-5:0], key_code};
                    digits_d = (digits_q < DIG_MAX) ? digits_q + DIG_ONE : DIG_MAX;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (AUTO_INC != 0) begin
                    adr_d   = adr_q + ADR_ONE;
                    state_d = RD_WAIT;
                    cnt_d   = RD_CNT;
                end else begin
                    digits_d = {DIG_W{1'b0}};
                    state_d  = IDLE;
                end
            end
            RD_WAIT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            CAPTURE: begin
                data_d   = bus.mem_rdata;
                digits_d = {DIG_W{1'b0}};
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        write_d = (state_d == WRITE);
        busy_d  = (state_d != IDLE);
    end

    // Panel registers; reset starts a readback of adr_init.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= RD_WAIT;
            cnt_q    <= RD_CNT;
            adr_q    <= adr_init;
            data_q   <= {DATA_W{1'b0}};
            digits_q <= {DIG_W{1'b0}};
            write_q  <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            adr_q    <= adr_d;
            data_q   <= data_d;
            digits_q <= digits_d;
            write_q  <= write_d;
            busy_q   <= busy_d;
        end
    end

    // Step mode is a burst of one; phase_q records that the clken half was issued.
    always_comb begin
        gate_s      = running_q & ~prog & ~reset;
        mode_chg_s  = (run_mode != mode_q);
        stepping_s  = (run_mode == MODE_STEP) || (run_mode == MODE_BURST);
        pulse_ok_s  = gate_s & ~mode_chg_s & (rem_q != BURST_ZERO);
        if (stepping_s) begin
            clken_s     = tick & pulse_ok_s & ~phase_q;
            clken_oop_s = tick_oop & pulse_ok_s & phase_q;
        end else begin
            clken_s     = tick & gate_s;
            clken_oop_s = tick_oop & gate_s;
        end
        if (halt) begin
            running_d = 1'b0;
        end else if (run_restart) begin
            running_d = 1'b1;
        end else begin
            running_d = running_q;
        end
        rem_d   = rem_q;
        phase_d = phase_q;
        mode_d  = run_mode;
        if (!gate_s || mode_chg_s || !stepping_s) begin
            rem_d   = BURST_ZERO;
            phase_d = 1'b0;
        end else if (rem_q == BURST_ZERO) begin
            phase_d = 1'b0;
            if (step_req) begin
                rem_d = (run_mode == MODE_STEP) ? BURST_ONE : burst_len;
            end else begin
                rem_d = BURST_ZERO;
            end
        end else if (clken_s) begin
            phase_d = 1'b1;
        end else if (clken_oop_s) begin
            phase_d = 1'b0;
            rem_d   = rem_q - BURST_ONE;
        end else begin
            phase_d = phase_q;
        end
    end

    // Run-control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            running_q <= 1'b1;
            rem_q     <= BURST_ZERO;
            phase_q   <= 1'b0;
            mode_q    <= 2'b00;
        end else begin
            running_q <= running_d;
            rem_q     <= rem_d;
            phase_q   <= phase_d;
            mode_q    <= mode_d;
        end
    end

    assign bus.fp_adr   = adr_q;
    assign bus.fp_data  = data_q;
    assign bus.fp_write = write_q;
    assign bus.busy     = busy_q;
    assign digits       = digits_q;
    assign running      = running_q;
    assign clken        = clken_s;
    assign clken_oop    = clken_oop_s;
endmodule

// File: tb/tb_front_panel_ctrl.sv
// Randomised and directed checks of front_panel_ctrl against a transaction-level panel model.
module tb_front_panel_ctrl;
    localparam int RD_LAT = 1;

    logic       clk = 1'b0;
    logic       reset, prog, adr_load, adr_inc, adr_dec, key_valid, key_clear, write_req;
    logic [3:0] adr_init, key_code;
    logic [1:0] run_mode;
    logic       step_req, tick, tick_oop, halt, run_restart;
    logic [7:0] burst_len;
    logic [1:0] digits;
    logic       clken, clken_oop, running;

    int total = 0;
    int bad   = 0;

    logic [7:0] mem [16];
    bit         mem_ready = 1'b0;

    logic [3:0] m_adr;
    logic [7:0] m_data;
    int         m_digits;
    int         m_left;
    bit         m_in_write;
    logic [7:0] m_mem [16];

    front_panel_ctrl_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    front_panel_ctrl #(.ADDR_W(4), .DATA_W(8), .BURST_W(8), .RD_LAT(RD_LAT), .AUTO_INC(1)) dut (
        .clk(clk), .reset(reset), .prog(prog), .adr_init(adr_init), .adr_load(adr_load),
        .adr_inc(adr_inc), .adr_dec(adr_dec), .key_valid(key_valid), .key_code(key_code),
        .key_clear(key_clear), .write_req(write_req), .run_mode(run_mode), .step_req(step_req),
        .burst_len(burst_len), .tick(tick), .tick_oop(tick_oop), .halt(halt),
        .run_restart(run_restart), .bus(bus), .digits(digits), .clken(clken),
        .clken_oop(clken_oop), .running(running)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        logic [7:0] v;
        v = 8'(i * 59 + 17);
        if (i == 3) v = 8'hA5;
        return v;
    endfunction

    // Memory with one cycle of read latency; accepts deposits from the panel.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else if (bus.fp_write === 1'b1) begin
            mem[bus.fp_adr] <= bus.fp_data;
        end
        bus.mem_rdata <= mem[bus.fp_adr];
    end

    // Panel model: busy time counted in cycles, readback = model memory at the address.
    task automatic model_edge();
        if (reset) begin
            m_adr = adr_init; m_data = 8'h00; m_digits = 0;
            m_left = RD_LAT + 1; m_in_write = 1'b0;
        end else if (m_left == 0) begin
            if (prog && write_req) begin
                m_in_write = 1'b1; m_left = 1;
            end else if (adr_load) begin
                m_adr = adr_init; m_left = RD_LAT + 1;
            end else if (adr_inc && !adr_dec) begin
                m_adr = m_adr + 4'd1; m_left = RD_LAT + 1;
            end else if (adr_dec && !adr_inc) begin
                m_adr = m_adr - 4'd1; m_left = RD_LAT + 1;
            end else if (prog && key_clear) begin
                m_data = 8'h00; m_digits = 0;
            end else if (prog && key_valid) begin
                m_data = {m_data[3:0], key_code};
                m_digits = (m_digits < 2) ? m_digits + 1 : 2;
            end
        end else begin
            m_left--;
            if (m_in_write) begin
                m_in_write = 1'b0;
                m_mem[m_adr] = m_data;
                m_adr = m_adr + 4'd1;
                m_left = RD_LAT + 1;
            end else if (m_left == 0) begin
                m_data = m_mem[m_adr]; m_digits = 0;
            end
        end
    endtask

    task automatic tick_clk();
        model_edge();
        @(posedge clk); #1;
        adr_load = 1'b0; adr_inc = 1'b0; adr_dec = 1'b0; key_valid = 1'b0; key_clear = 1'b0;
        write_req = 1'b0; step_req = 1'b0; halt = 1'b0; run_restart = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy === 1'b1 && n < 20) begin tick_clk(); n++; end
        total++;
        if (bus.busy !== 1'b0) begin bad++; $display("FAIL wait_idle busy=%b required 0", bus.busy); end
    endtask

    task automatic run_pairs(input int n, output int c, output int co);
        c = 0; co = 0;
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; #1;
            if (clken === 1'b1) c++;
            if (clken_oop === 1'b1) co++;
            tick_clk(); tick = 1'b0;
            tick_oop = 1'b1; #1;
            if (clken === 1'b1) c++;
            if (clken_oop === 1'b1) co++;
            tick_clk(); tick_oop = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; adr_init = 4'h3;
        tick_clk();
        tick = 1'b1; #1;
        total++;
        if (clken !== 1'b0) begin bad++; $display("FAIL reset_clken got %b want 0", clken); end
        tick = 1'b0;
        total++;
        if (bus.fp_adr !== 4'h3 || bus.busy !== 1'b1 || bus.fp_data !== 8'h00 || digits !== 2'd0
            || bus.fp_write !== 1'b0 || running !== 1'b1) begin
            bad++;
            $display("FAIL reset_state adr=%h busy=%b data=%h dig=%0d wr=%b run=%b want 3 1 00 0 0 1",
                     bus.fp_adr, bus.busy, bus.fp_data, digits, bus.fp_write, running);
        end
        reset = 1'b0;
        tick_clk();
        tick_clk();
        total++;
        if (bus.fp_data !== 8'hA5 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL reset_readback data=%h busy=%b want a5 0", bus.fp_data, bus.busy);
        end
    endtask

    task automatic test_keys();
        logic [3:0] keys [3];
        logic [7:0] exp_d [3];
        logic [1:0] exp_n [3];
        keys = '{4'h1, 4'h2, 4'h3};
        exp_d = '{8'h01, 8'h12, 8'h23};
        exp_n = '{2'd1, 2'd2, 2'd2};
        prog = 1'b1; key_clear = 1'b1;
        tick_clk();
        total++;
        if (bus.fp_data !== 8'h00 || digits !== 2'd0) begin
            bad++; $display("FAIL key_clear data=%h dig=%0d want 00 0", bus.fp_data, digits);
        end
        for (int i = 0; i < 3; i++) begin
            key_valid = 1'b1; key_code = keys[i];
            tick_clk();
            total++;
            if (bus.fp_data !== exp_d[i] || digits !== exp_n[i]) begin
                bad++; $display("FAIL key_entry%0d data=%h dig=%0d want %h %0d", i, bus.fp_data, digits, exp_d[i], exp_n[i]);
            end
        end
    endtask

    task automatic test_write();
        write_req = 1'b1;
        tick_clk();
        total++;
        if (bus.fp_write !== 1'b1 || bus.fp_adr !== 4'h3 || bus.fp_data !== 8'h23) begin
            bad++; $display("FAIL write_strobe wr=%b adr=%h data=%h want 1 3 23", bus.fp_write, bus.fp_adr, bus.fp_data);
        end
        tick_clk();
        total++;
        if (bus.fp_write !== 1'b0 || bus.fp_adr !== 4'h4) begin
            bad++; $display("FAIL write_after wr=%b adr=%h want 0 4", bus.fp_write, bus.fp_adr);
        end
        wait_idle();
        total++;
        if (bus.fp_data !== init_val(4) || mem[3] !== 8'h23) begin
            bad++; $display("FAIL write_reload data=%h mem3=%h want %h 23", bus.fp_data, mem[3], init_val(4));
        end
    endtask

    task automatic test_wrap();
        adr_init = 4'hF; adr_load = 1'b1;
        tick_clk(); wait_idle();
        adr_inc = 1'b1;
        tick_clk();
        total++;
        if (bus.fp_adr !== 4'h0) begin bad++; $display("FAIL wrap_inc adr=%h want 0", bus.fp_adr); end
        wait_idle();
        adr_dec = 1'b1;
        tick_clk();
        total++;
        if (bus.fp_adr !== 4'hF) begin bad++; $display("FAIL wrap_dec adr=%h want f", bus.fp_adr); end
        wait_idle();
        adr_inc = 1'b1; adr_dec = 1'b1;
        tick_clk();
        total++;
        if (bus.fp_adr !== 4'hF || bus.busy !== 1'b0) begin
            bad++; $display("FAIL inc_dec adr=%h busy=%b want f 0", bus.fp_adr, bus.busy);
        end
        key_clear = 1'b1; tick_clk();
        key_valid = 1'b1; key_code = 4'h7; tick_clk();
        write_req = 1'b1; key_valid = 1'b1; key_code = 4'h9;
        tick_clk();
        total++;
        if (bus.fp_write !== 1'b1 || bus.fp_data !== 8'h07) begin
            bad++; $display("FAIL write_vs_key wr=%b data=%h want 1 07", bus.fp_write, bus.fp_data);
        end
        wait_idle();
        total++;
        if (mem[15] !== 8'h07 || bus.fp_adr !== 4'h0) begin
            bad++; $display("FAIL write_wrap mem15=%h adr=%h want 07 0", mem[15], bus.fp_adr);
        end
    endtask

    task automatic test_random_panel();
        for (int i = 0; i < 400; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            prog      = ($urandom_range(0, 3) != 0);
            adr_init  = 4'($urandom);
            adr_load  = ($urandom_range(0, 15) == 0);
            adr_inc   = ($urandom_range(0, 7) == 0);
            adr_dec   = ($urandom_range(0, 7) == 0);
            key_valid = ($urandom_range(0, 2) == 0);
            key_clear = ($urandom_range(0, 15) == 0);
            write_req = ($urandom_range(0, 9) == 0);
            key_code  = 4'($urandom);
            tick_clk();
            total++;
            if (bus.fp_adr !== m_adr || bus.fp_data !== m_data || digits !== 2'(m_digits)
                || bus.busy !== (m_left != 0) || bus.fp_write !== m_in_write) begin
                bad++;
                $display("FAIL random_panel cyc%0d adr=%h data=%h dig=%0d busy=%b wr=%b want %h %h %0d %b %b",
                         i, bus.fp_adr, bus.fp_data, digits, bus.busy, bus.fp_write,
                         m_adr, m_data, m_digits, (m_left != 0), m_in_write);
            end
        end
        reset = 1'b0; prog = 1'b0;
        wait_idle();
    endtask

    task automatic test_burst();
        int c, co, exp_n;
        int lens [3];
        lens = '{3, 0, int'($urandom_range(1, 12))};
        prog = 1'b0; run_restart = 1'b1; run_mode = 2'b10;
        tick_clk(); tick_clk();
        for (int k = 0; k < 3; k++) begin
            burst_len = 8'(lens[k]); step_req = 1'b1;
            tick_clk();
            run_pairs(10, c, co);
            exp_n = (lens[k] < 10) ? lens[k] : 10;
            total++;
            if (c !== exp_n || co !== exp_n) begin
                bad++; $display("FAIL burst len=%0d clken=%0d oop=%0d want %0d", lens[k], c, co, exp_n);
            end
        end
        burst_len = 8'd5; step_req = 1'b1;
        tick_clk();
        run_pairs(1, c, co);
        run_mode = 2'b01;
        tick_clk();
        run_pairs(3, c, co);
        total++;
        if (c !== 0 || co !== 0) begin bad++; $display("FAIL mode_cancel clken=%0d oop=%0d want 0 0", c, co); end
    endtask

    task automatic test_auto_halt();
        run_mode = 2'b00; tick = 1'b1;
        tick_clk();
        total++;
        if (clken !== 1'b1) begin bad++; $display("FAIL auto_run clken=%b want 1", clken); end
        halt = 1'b1;
        tick_clk();
        total++;
        if (clken !== 1'b0 || running !== 1'b0) begin
            bad++; $display("FAIL halt clken=%b run=%b want 0 0", clken, running);
        end
        run_restart = 1'b1;
        tick_clk();
        total++;
        if (clken !== 1'b1 || running !== 1'b1) begin
            bad++; $display("FAIL restart clken=%b run=%b want 1 1", clken, running);
        end
        halt = 1'b1; run_restart = 1'b1;
        tick_clk();
        total++;
        if (running !== 1'b0 || clken !== 1'b0) begin
            bad++; $display("FAIL halt_vs_restart run=%b clken=%b want 0 0", running, clken);
        end
        tick = 1'b0; run_restart = 1'b1;
        tick_clk();
    endtask

    task automatic test_step();
        int c, co;
        run_mode = 2'b01;
        tick_clk(); tick_clk();
        step_req = 1'b1; tick_clk();
        step_req = 1'b1; tick_clk();
        run_pairs(3, c, co);
        total++;
        if (c !== 1 || co !== 1) begin bad++; $display("FAIL step_double clken=%0d oop=%0d want 1 1", c, co); end
        step_req = 1'b1; tick_clk();
        prog = 1'b1;
        run_pairs(2, c, co);
        prog = 1'b0;
        run_pairs(2, c, co);
        total++;
        if (c !== 0 || co !== 0) begin bad++; $display("FAIL step_prog_cancel clken=%0d oop=%0d want 0 0", c, co); end
        step_req = 1'b1; tick_clk();
        run_pairs(2, c, co);
        total++;
        if (c !== 1 || co !== 1) begin bad++; $display("FAIL step_again clken=%0d oop=%0d want 1 1", c, co); end
    endtask

    initial begin
        reset = 1'b1; prog = 1'b0; adr_init = 4'h3; adr_load = 1'b0; adr_inc = 1'b0; adr_dec = 1'b0;
        key_valid = 1'b0; key_code = 4'h0; key_clear = 1'b0; write_req = 1'b0; run_mode = 2'b00;
        step_req = 1'b0; burst_len = 8'd0; tick = 1'b0; tick_oop = 1'b0; halt = 1'b0; run_restart = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = init_val(i);
        test_reset();
        test_keys();
        test_write();
        test_wrap();
        test_random_panel();
        test_burst();
        test_auto_halt();
        test_step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
